mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl_if.sv | 25 ++
 rtl/mux_scan_ctrl.sv | 84 ++++++++
 tb/tb_mux_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// Channel-select and result handshake bundle between
// the scan sequencer, its 4:1 mux and the result consumer.
interface mux_scan_ctrl_if;
  logic [1:0] sel;
  logic       y_in;
  logic [3:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output sel,
    output data,
    output valid,
    input  y_in,
    input  ready
  );

  modport slave (
    input  sel,
    input  data,
    input  valid,
    output y_in,
    output ready
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps sel over channels 0..3,
// samples y_in after a settle time, hands off a 4-bit word.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  mux_scan_ctrl_if.master bus
);

  localparam int CW =
    ($clog2(DWELL) < 1) ? 1 : $clog2(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      bus.sel   <= '0;
      bus.data  <= '0;
      bus.valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= SCAN;
            busy    <= 1'b1;
            cnt     <= '0;
            shadow  <= '0;
            bus.sel <= '0;
          end
        end
        SCAN: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (bus.sel != 2'd3) begin
              shadow  <= shadow |
                (3'(bus.y_in) << bus.sel);
              bus.sel <= bus.sel + 2'd1;
            end else begin
              // channel 3 bypasses shadow: it is
              // sampled on the same edge data loads
              bus.data  <= {bus.y_in, shadow};
              bus.valid <= 1'b1;
              bus.sel   <= '0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.ready) begin
            bus.valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          bus.sel   <= '0;
          bus.valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with DWELL=2
// and DWELL=1 instances fed by behavioural 4:1 muxes.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start0;
  logic       start1;
  logic       busy0;
  logic       busy1;
  logic [3:0] a0;
  logic [3:0] a1;
  int         checks;
  int         errors;

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if1 ();

  assign if0.y_in = a0[if0.sel];
  assign if1.y_in = a1[if1.sel];

  mux_scan_ctrl #(.DWELL(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start0),
    .busy  (busy0),
    .bus   (if0.master)
  );

  mux_scan_ctrl #(.DWELL(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .busy  (busy1),
    .bus   (if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n  = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if0.sel !== 2'd0 || if0.data !== 4'd0 ||
          if0.valid !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: sel=%0d data=%b valid=%b busy=%b, need 0 0000 0 0",
                 i, if0.sel, if0.data, if0.valid, busy0);
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy0=%b busy1=%b, need 0 0",
               busy0, busy1);
    end
  endtask

  task automatic test_basic();
    a0         = 4'b1010;
    if0.ready  = 1'b1;
    start0     = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (if0.sel !== 2'(i / 2) || if0.valid !== 1'b0 ||
          busy0 !== 1'b1) begin
        errors++;
        $display("FAIL basic_seq cyc%0d: sel=%0d valid=%b busy=%b, need %0d 0 1",
                 i + 1, if0.sel, if0.valid, busy0, i / 2);
      end
      @(negedge clk);
    end
    checks++;
    if (if0.valid !== 1'b1 || if0.data !== 4'b1010 ||
        busy0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_result: valid=%b data=%b busy=%b, need 1 1010 1",
               if0.valid, if0.data, busy0);
    end
    @(negedge clk);
    checks++;
    if (if0.valid !== 1'b0 || busy0 !== 1'b0 ||
        if0.data !== 4'b1010) begin
      errors++;
      $display("FAIL basic_after: valid=%b busy=%b data=%b, need 0 0 1010",
               if0.valid, busy0, if0.data);
    end
  endtask

  task automatic test_backpressure();
    a0        = 4'b1010;
    if0.ready = 1'b0;
    start0    = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (if0.valid !== 1'b1 || busy0 !== 1'b1 ||
          if0.data !== 4'b1010) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: valid=%b busy=%b data=%b, need 1 1 1010",
                 i, if0.valid, busy0, if0.data);
      end
      @(negedge clk);
    end
    if0.ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if0.valid !== 1'b0 || busy0 !== 1'b0 ||
        if0.data !== 4'b1010) begin
      errors++;
      $display("FAIL bp_release: valid=%b busy=%b data=%b, need 0 0 1010",
               if0.valid, busy0, if0.data);
    end
  endtask

  task automatic test_ignored_start();
    int vcount;
    vcount    = 0;
    a0        = 4'b0000;
    if0.ready = 1'b1;
    start0    = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (if0.valid === 1'b1) vcount++;
      if (i == 5) a0 = 4'b1111;
      start0 = (i == 2 || i == 6 || i == 8);
      if (i == 9) begin
        checks++;
        if (if0.valid !== 1'b1 || if0.data !== 4'b1100) begin
          errors++;
          $display("FAIL midchange_data: valid=%b data=%b, need 1 1100",
                   if0.valid, if0.data);
        end
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++;
    if (vcount !== 1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: valid_cycles=%0d busy=%b, need 1 0",
               vcount, busy0);
    end
  endtask

  task automatic test_reset_mid();
    a0        = 4'b1111;
    if0.ready = 1'b1;
    start0    = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (if0.sel !== 2'd2 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: sel=%0d busy=%b, need 2 1",
               if0.sel, busy0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if0.sel !== 2'd0 || if0.data !== 4'd0 ||
        if0.valid !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: sel=%0d data=%b valid=%b busy=%b, need 0 0000 0 0",
               if0.sel, if0.data, if0.valid, busy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a0     = 4'b0101;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (if0.valid !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_latency: valid=%b busy=%b at cycle 8, need 0 1",
               if0.valid, busy0);
    end
    @(negedge clk);
    checks++;
    if (if0.valid !== 1'b1 || if0.data !== 4'b0101) begin
      errors++;
      $display("FAIL rstmid_result: valid=%b data=%b, need 1 0101",
               if0.valid, if0.data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] esel;
    logic       evalid;
    logic       ebusy;
    a1        = 4'b1001;
    if1.ready = 1'b1;
    start1    = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      esel   = 2'd0;
      if (i >= 1 && i <= 4) esel = 2'(i - 1);
      if (i >= 7 && i <= 10) esel = 2'(i - 7);
      evalid = (i == 5 || i == 11);
      ebusy  = (i != 6 && i != 12);
      checks++;
      if (if1.sel !== esel || if1.valid !== evalid ||
          busy1 !== ebusy) begin
        errors++;
        $display("FAIL b2b cyc%0d: sel=%0d valid=%b busy=%b, need %0d %b %b",
                 i, if1.sel, if1.valid, busy1, esel, evalid, ebusy);
      end
      if (evalid) begin
        checks++;
        if (if1.data !== 4'b1001) begin
          errors++;
          $display("FAIL b2b_data cyc%0d: data=%b, need 1001",
                   i, if1.data);
        end
      end
      start1 = (i == 6);
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    a0        = 4'd0;
    a1        = 4'd0;
    start0    = 1'b0;
    start1    = 1'b0;
    if0.ready = 1'b0;
    if1.ready = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
